// File: rtl/psum_accum.sv
// Partial-sum accumulator: sums LEN beats of i_psum into one registered result with a
// valid/ready handshake on both sides. Saturation is enabled by defining PSUM_ACCUM_SAT_EN.
module psum_accum #(
   parameter int unsigned BW    = 8,
   parameter int unsigned ACC_W = 32,
   parameter int unsigned LEN   = 16
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic [2*BW-1:0]   i_psum,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_flush,
   output logic [ACC_W-1:0]  o_acc,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [15:0]       o_count,
   output logic              o_ovf
);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] res_q, res_d;
   logic [15:0]      count_q, count_d;
   logic             valid_q, valid_d;
   logic [ACC_W-1:0] base;
   logic [ACC_W-1:0] sum;
   logic [15:0]      count_inc;
   logic             last;

   assign o_ready   = (state_q != StHold);
   assign o_acc     = res_q;
   assign o_valid   = valid_q;
   assign o_count   = count_q;

   // First beat of a result loads rather than adds, so stale acc never leaks in.
   assign base      = (count_q == 16'd0) ? '0 : acc_q;
   assign count_inc = count_q + 16'd1;
   assign last      = (count_inc == 16'(LEN));

`ifdef PSUM_ACCUM_SAT_EN
   logic [ACC_W:0] sum_wide;
   logic           overflow;
   logic           ovf_q, ovf_d;

   assign sum_wide = {1'b0, base} + (ACC_W+1)'(i_psum);
   assign overflow = sum_wide[ACC_W];
   assign sum      = overflow ? '1 : sum_wide[ACC_W-1:0];
   assign o_ovf    = ovf_q;

   always_comb begin
      ovf_d = ovf_q;
      if (i_flush) begin
         ovf_d = 1'b0;
      end else if (state_q == StHold) begin
         if (i_ready) ovf_d = 1'b0;
      end else if (i_valid && overflow) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) ovf_q <= 1'b0;
      else            ovf_q <= ovf_d;
   end
`else
   assign sum   = base + ACC_W'(i_psum);
   assign o_ovf = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;
      res_d   = res_q;
      valid_d = valid_q;
      if (i_flush) begin
         state_d = StIdle;
         acc_d   = '0;
         count_d = 16'd0;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StAccum: begin
               if (i_valid) begin
                  acc_d   = sum;
                  count_d = count_inc;
                  if (last) begin
                     res_d   = sum;
                     valid_d = 1'b1;
                     state_d = StHold;
                  end else begin
                     state_d = StAccum;
                  end
               end
            end
            StHold: begin
               if (i_ready) begin
                  valid_d = 1'b0;
                  count_d = 16'd0;
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         res_q   <= '0;
         count_q <= 16'd0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         count_q <= count_d;
         valid_q <= valid_d;
      end
   end

endmodule
